riscv_core_fetch_pc: RTL and testbench
======================================

// Module: riscv_core_fetch_pc
// PURPOSE
//  IF-stage PC register plus instruction-fetch controller. Consumes the next-PC
//  2:1 mux result (PC+4 vs branch/jump target, select = redirect) as i_redirect/
//  i_redirect_pc, issues word fetches over a req/gnt/rvalid IMEM port, buffers
//  responses in a small FIFO, and presents {pc,instr} to the IF/ID register via valid/ready.
// PARAMETERS
//  XLEN        32            address/data width
//  RESET_PC    32'h0000_0000 PC loaded on reset (bits [1:0] must be 0)
//  FIFO_DEPTH  2             response buffer entries; power of 2, >= 2
//  CNT_WIDTH   32            perf counter width (RISCV_CORE_FETCH_PERF_EN only)
// PORTS
//  i_clk           in   1          core clock
//  i_rst           in   1          asynchronous reset, active-high
//  i_redirect      in   1          taken branch/jump/trap: flush and refetch
//  i_redirect_pc   in   XLEN       redirect target; bits [1:0] ignored (word fetch)
//  o_imem_req      out  1          fetch request
//  o_imem_addr     out  XLEN       word-aligned fetch address
//  i_imem_gnt      in   1          request accepted this cycle
//  i_imem_rvalid   in   1          response valid (in order, >=1 cycle after gnt)
//  i_imem_rdata    in   XLEN       fetched word
//  o_if_valid      out  1          {o_if_pc,o_if_instr} valid
//  o_if_pc         out  XLEN       PC of presented word
//  o_if_instr      out  XLEN       fetched word (RVC realign is downstream)
//  i_if_ready      in   1          IF/ID accepts this cycle
//  o_fetch_cnt     out  CNT_WIDTH  words delivered (only with RISCV_CORE_FETCH_PERF_EN)
//  o_drop_cnt      out  CNT_WIDTH  responses discarded (only with RISCV_CORE_FETCH_PERF_EN)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=IDLE, FIFO empty, o_imem_req=0, o_imem_addr=RESET_PC,
//    o_if_valid=0, o_if_pc=RESET_PC, o_if_instr=NOP(32'h0000_0013); counters 0.
//  - At most ONE outstanding granted request. States:
//    IDLE : 1 cycle after reset release -> REQ.
//    REQ  : o_imem_req=1 iff fifo_count < FIFO_DEPTH; addr=pc. gnt -> WAIT, pc+=4.
//    WAIT : rvalid -> push {addr_of_req,rdata}; -> REQ (req may assert same cycle).
//    DROP : stale response pending; rvalid -> discard, -> REQ.
//  - o_imem_addr stable while req && !gnt, except on redirect (addr may change pre-grant).
//  - Redirect (highest priority, any state): pc<=i_redirect_pc&~3, FIFO flushed
//    (o_if_valid=0 next cycle), pop that cycle ignored. In WAIT, or in REQ with gnt
//    same cycle -> DROP. In DROP, stays DROP. Else -> REQ. Redirect+rvalid in WAIT:
//    response discarded, -> REQ.
//  - FIFO: o_if_valid = !empty; pop on o_if_valid&&i_if_ready; push+pop same cycle
//    allowed at full. Never overflows: req gated by count. Empty -> NOP/last-PC-invalid.
//  - Latency: gnt at cycle t, rvalid at t+1 -> o_if_valid at t+2 (registered FIFO).
//  - PC arithmetic mod 2^XLEN; 0xFFFF_FFFC+4 wraps to 0, no flag.
//  - Reset mid-operation clears all state; IMEM is reset together, no late rvalid.
// CONFIGURATION
//  RISCV_CORE_FETCH_PERF_EN defined: o_fetch_cnt +1 per pop, o_drop_cnt +1 per
//  discarded rvalid (DROP, or redirect in WAIT); both wrap silently.
//  Undefined: ports and counters absent; functional behaviour identical.
// STRUCTURE
//  riscv_core_pkg: XLEN, NOP_INSTR, fetch_state_e {IDLE,REQ,WAIT,DROP},
//  fetch_entry_t struct {pc, instr}.
//  Sub-module riscv_core_fetch_fifo (DEPTH, fetch_entry_t, push/pop/flush/count).
// TESTING
//  1 reset, gnt=1, rvalid 1 cycle later, ready=1 -> pcs 0x0,0x4,0x8 at 1 word/2 cyc.
//  2 ready=0 for 6 cycles -> 2 entries held, req drops, no overflow; resume in order.
//  3 redirect to 0x100 while WAIT -> old rdata dropped, next o_if_pc=0x100, drop_cnt=1.
//  4 redirect 0x203 same cycle as gnt -> DROP, fetch addr 0x200, FIFO empty next cyc.
//  5 gnt withheld 3 cycles -> req held, addr constant; redirect mid-wait -> addr updates.
//  6 assert i_rst during WAIT -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// riscv_core_pkg: shared types and constants for the core front end.
// Holds the fetch FSM state encoding and the {pc,instr} entry carried from
// the IMEM response port through the fetch buffer to the IF/ID register.
package riscv_core_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- presented on the instruction bus whenever nothing is valid
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // one cycle after reset release
    REQ  = 2'd1,  // presenting a fetch request
    WAIT = 2'd2,  // granted, response outstanding
    DROP = 2'd3   // granted before a redirect, response must be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscv_core_fetch_fifo.sv
// riscv_core_fetch_fifo: circular buffer of fetched {pc,instr} entries.
// Flush wins over push and pop in the same cycle; push and pop together are
// legal even when full (the popped slot is reused). The head entry is read
// straight out of the storage registers, so data is visible the cycle after push.
module riscv_core_fetch_fifo
  import riscv_core_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  output fetch_entry_t           head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && ((count_q != FULL) || do_pop);

  // Pointer / occupancy next-state; flush returns to the empty state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer / occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/riscv_core_fetch_pc.sv
// riscv_core_fetch_pc: IF-stage PC register and instruction-fetch controller.
// Issues word fetches over a req/gnt/rvalid IMEM port with at most one granted
// request outstanding, buffers responses and hands {pc,instr} to IF/ID.
// A redirect flushes the buffer and retargets the PC; a response already in
// flight when the redirect lands is discarded via the DROP state.
// Optional: define RISCV_CORE_FETCH_PERF_EN to add the delivered/dropped
// word counters (o_fetch_cnt / o_drop_cnt) and the CNT_WIDTH parameter.
module riscv_core_fetch_pc #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
`ifdef RISCV_CORE_FETCH_PERF_EN
  ,
  parameter int              CNT_WIDTH  = 32
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_instr,
  input  logic            i_if_ready
`ifdef RISCV_CORE_FETCH_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] o_fetch_cnt,
  output logic [CNT_WIDTH-1:0] o_drop_cnt
`endif
);
  import riscv_core_pkg::*;

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;            // next address to fetch
  logic [XLEN-1:0] req_addr_q, req_addr_d; // address of the outstanding request
  logic [XLEN-1:0] last_pc_q;             // PC shown while the buffer is empty
  logic            imem_req;
  logic            fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    push_entry, head;

  assign push_entry = '{pc: req_addr_q, instr: i_imem_rdata};

  // Fetch FSM next-state; redirect is applied last so it overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    imem_req   = 1'b0;
    fifo_push  = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // one request in flight at most, so a free slot now is a free slot at push
        imem_req = (fifo_count < DEPTH_C);
        if (imem_req && i_imem_gnt) begin
          state_d    = WAIT;
          req_addr_d = pc_q;
          pc_d       = pc_q + XLEN'(4);
        end
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          fifo_push = 1'b1;
          state_d   = REQ;
        end
      end
      DROP: begin
        if (i_imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (i_redirect) begin
      pc_d      = i_redirect_pc & ~XLEN'(3);
      fifo_push = 1'b0;
      case (state_q)
        WAIT:    state_d = i_imem_rvalid ? REQ : DROP;
        REQ:     state_d = (imem_req && i_imem_gnt) ? DROP : REQ;
        // a redirect in DROP still owes one stale response unless it arrives now
        DROP:    state_d = i_imem_rvalid ? REQ : DROP;
        default: state_d = REQ;
      endcase
    end
  end

  // FSM / PC registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  // Remember the last PC handed to IF/ID so o_if_pc is stable when empty.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                        last_pc_q <= RESET_PC;
    else if (fifo_pop && !i_redirect) last_pc_q <= head.pc;
  end

  assign fifo_pop = o_if_valid && i_if_ready;

  riscv_core_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .flush_i     (i_redirect),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign o_imem_req  = imem_req;
  assign o_imem_addr = pc_q;
  assign o_if_valid  = !fifo_empty;
  assign o_if_pc     = fifo_empty ? last_pc_q : head.pc;
  assign o_if_instr  = fifo_empty ? NOP_INSTR : head.instr;

`ifdef RISCV_CORE_FETCH_PERF_EN
  logic [CNT_WIDTH-1:0] fetch_cnt_q, drop_cnt_q;
  logic                 drop_ev;

  // A response is thrown away in DROP, or when a redirect meets it in WAIT.
  assign drop_ev = i_imem_rvalid &&
                   ((state_q == DROP) || ((state_q == WAIT) && i_redirect));

  // Free-running perf counters; wrap silently.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (fifo_pop && !i_redirect) fetch_cnt_q <= fetch_cnt_q + CNT_WIDTH'(1);
      if (drop_ev)                 drop_cnt_q  <= drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_fetch_cnt = fetch_cnt_q;
  assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_core_fetch_pc.sv
// tb_riscv_core_fetch_pc: randomized IMEM / IF-ID environment around the fetch
// unit. The reference model only knows that delivered words form a contiguous
// +4 stream starting at the reset PC or the last redirect target, and that
// each word's data is a fixed hash of its address.
`timescale 1ns/1ps
module tb_riscv_core_fetch_pc;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect, gnt, rvalid, ready;
  logic [31:0] redirect_pc, rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_pc, if_instr;
`ifdef RISCV_CORE_FETCH_PERF_EN
  logic [31:0] fetch_cnt, drop_cnt;
`endif

  riscv_core_fetch_pc #(
    .XLEN       (32),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
`ifdef RISCV_CORE_FETCH_PERF_EN
    ,
    .CNT_WIDTH  (32)
`endif
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .o_if_valid    (if_valid),
    .o_if_pc       (if_pc),
    .o_if_instr    (if_instr),
    .i_if_ready    (ready)
`ifdef RISCV_CORE_FETCH_PERF_EN
    ,
    .o_fetch_cnt   (fetch_cnt),
    .o_drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  // stimulus knobs
  int gnt_pct, rdy_pct, redir_pct, lat_min, lat_max;
  bit force_redir = 0, redir_if_req = 0;
  logic [31:0] force_tgt;
  // IMEM responder
  bit pend = 0, stale = 0;
  logic [31:0] pend_addr;
  int pend_dly = 0;
  // reference model / bookkeeping
  logic [31:0] exp_pc, last_pop_pc = 32'h0, last_gnt_addr = 32'h0;
  int pops = 0, n_gnt = 0, exp_drop = 0, exp_fetch = 0;
  int first_gnt_cyc = -1, first_vld_cyc = -1;
  int pop_cyc[$];
  bit prev_hold = 0, seen_wrap = 0;
  logic [31:0] prev_addr = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  // One clock: sample at negedge, drive inputs for the coming posedge, update model.
  task automatic tick();
    logic busy;
    @(negedge clk);
    cyc++;
    if (prev_hold) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_stable", imem_addr, prev_addr);
    end
    if (!if_valid) check("empty_nop", if_instr, NOP);
    if (if_valid && first_vld_cyc < 0) first_vld_cyc = cyc;

    redirect    = 1'b0;
    redirect_pc = $urandom;
    if (force_redir || (redir_if_req && imem_req)) begin
      redirect     = 1'b1;
      redirect_pc  = force_tgt;
      force_redir  = 0;
      redir_if_req = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      redirect = 1'b1;
    end
    ready = ($urandom_range(99) < rdy_pct);

    busy   = pend;
    rvalid = 1'b0;
    rdata  = $urandom;
    if (pend) begin
      if (pend_dly == 0) begin
        rvalid = 1'b1;
        rdata  = mem_word(pend_addr);
        pend   = 0;
        if (stale || redirect) exp_drop++;
      end else begin
        pend_dly--;
        if (redirect) stale = 1;
      end
    end
    if (imem_req) check("one_outstanding", 32'(busy), 32'd0);

    gnt = imem_req && ($urandom_range(99) < gnt_pct);
    if (gnt) begin
      pend          = 1;
      pend_addr     = imem_addr;
      pend_dly      = int'($urandom_range(lat_max, lat_min)) - 1;
      stale         = redirect;
      n_gnt++;
      last_gnt_addr = imem_addr;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
    end
    prev_hold = imem_req && !gnt && !redirect;
    prev_addr = imem_addr;

    if (redirect) begin
      exp_pc = redirect_pc & ~32'h3;
    end else if (if_valid && ready) begin
      check("pop_pc", if_pc, exp_pc);
      check("pop_instr", if_instr, mem_word(exp_pc));
      if (if_pc == 32'h0 && last_pop_pc == 32'hFFFF_FFFC) seen_wrap = 1;
      last_pop_pc = if_pc;
      exp_pc      = exp_pc + 32'd4;
      pops++;
      exp_fetch++;
      pop_cyc.push_back(cyc);
    end
  endtask

  task automatic set_knobs(input int g, input int r, input int d, input int lmin, input int lmax);
    gnt_pct = g; rdy_pct = r; redir_pct = d; lat_min = lmin; lat_max = lmax;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(imem_req), 32'd0);
    check({tag, "_addr"},  imem_addr, RST_PC);
    check({tag, "_valid"}, 32'(if_valid), 32'd0);
    check({tag, "_pc"},    if_pc, RST_PC);
    check({tag, "_instr"}, if_instr, NOP);
`ifdef RISCV_CORE_FETCH_PERF_EN
    check({tag, "_fcnt"},  fetch_cnt, 32'd0);
    check({tag, "_dcnt"},  drop_cnt, 32'd0);
`endif
  endtask

  task automatic wait_pop(input string tag);
    int base;
    base = pops;
    for (int k = 0; k < 40 && pops == base; k++) tick();
    check(tag, 32'(pops > base), 32'd1);
  endtask

  initial begin
    logic [31:0] a0;
    int base_g;
    rst = 1'b0; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0;
    rvalid = 1'b0; rdata = '0; ready = 1'b0; force_tgt = '0;
    set_knobs(100, 100, 0, 1, 1);
    #1 rst = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_pc = RST_PC;

    // 1: streaming at one word per two cycles
    repeat (10) tick();
    check("t1_latency", 32'(first_vld_cyc - first_gnt_cyc), 32'd2);
    check("t1_pop_count", 32'(pop_cyc.size() >= 3), 32'd1);
    if (pop_cyc.size() >= 3) begin
      check("t1_rate0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
      check("t1_rate1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
    end

    // 2: backpressure fills the buffer and gates requests
    set_knobs(100, 0, 0, 1, 1);
    repeat (6) tick();
    @(posedge clk); #1;
    check("t2_full_valid", 32'(if_valid), 32'd1);
    check("t2_req_gated", 32'(imem_req), 32'd0);
    set_knobs(100, 100, 0, 1, 1);
    repeat (10) tick();

    // 3: redirect while a response is outstanding
    set_knobs(100, 100, 0, 2, 2);
    for (int k = 0; k < 20 && !(pend && pend_dly > 0); k++) tick();
    check("t3_in_wait", 32'(pend && pend_dly > 0), 32'd1);
    force_redir = 1; force_tgt = 32'h100;
    tick();
    wait_pop("t3_popped");
    check("t3_first_pc", last_pop_pc, 32'h100);
`ifdef RISCV_CORE_FETCH_PERF_EN
    @(posedge clk); #1;
    check("t3_drop_cnt", drop_cnt, 32'(exp_drop));
`endif

    // 4: redirect in the same cycle as a grant
    set_knobs(100, 100, 0, 1, 1);
    redir_if_req = 1; force_tgt = 32'h203;
    for (int k = 0; k < 20 && redir_if_req; k++) tick();
    check("t4_fired", 32'(redir_if_req), 32'd0);
    @(posedge clk); #1;
    check("t4_flushed", 32'(if_valid), 32'd0);
    base_g = n_gnt;
    for (int k = 0; k < 20 && n_gnt == base_g; k++) tick();
    check("t4_refetch_addr", last_gnt_addr, 32'h200);
    wait_pop("t4_popped");
    check("t4_first_pc", last_pop_pc, 32'h200);

    // 5: grant withheld, then redirect before the grant
    set_knobs(0, 100, 0, 1, 1);
    repeat (3) tick();
    @(posedge clk); #1;
    check("t5_req", 32'(imem_req), 32'd1);
    a0 = imem_addr;
    repeat (3) tick();
    @(posedge clk); #1;
    check("t5_req_held", 32'(imem_req), 32'd1);
    check("t5_addr_const", imem_addr, a0);
    force_redir = 1; force_tgt = 32'h3000;
    tick();
    @(posedge clk); #1;
    check("t5_addr_redir", imem_addr, 32'h3000);
    check("t5_req_redir", 32'(imem_req), 32'd1);
    set_knobs(100, 100, 0, 1, 1);
    repeat (10) tick();

    // PC wraps modulo 2^32
    force_redir = 1; force_tgt = 32'hFFFF_FFF8;
    repeat (14) tick();
    check("wrap_seen", 32'(seen_wrap), 32'd1);

    // random traffic
    set_knobs(70, 70, 3, 1, 4);
    repeat (3000) tick();

    // 6: asynchronous reset while waiting on a response
    set_knobs(100, 100, 0, 3, 3);
    for (int k = 0; k < 20 && !(pend && pend_dly > 0); k++) tick();
    check("t6_in_wait", 32'(pend && pend_dly > 0), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6");
    pend = 0; stale = 0; prev_hold = 0;
    gnt = 1'b0; rvalid = 1'b0; redirect = 1'b0;
    exp_pc = RST_PC; exp_drop = 0; exp_fetch = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    set_knobs(100, 100, 0, 1, 1);
    wait_pop("t6_restart_pop");
    check("t6_restart_pc", last_pop_pc, RST_PC);
    repeat (10) tick();

`ifdef RISCV_CORE_FETCH_PERF_EN
    @(posedge clk); #1;
    check("final_fetch_cnt", fetch_cnt, 32'(exp_fetch));
    check("final_drop_cnt", drop_cnt, 32'(exp_drop));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
